bn_act_sat_fp: RTL and testbench
================================

Name: bn_act_sat_fp

Overview:
- Fixed-point batch-norm plus activation stage for the per-channel datapath between conv/dense layers: y = act(sat((a*x + b + rnd) >>> R_SHIFT)).
- Successor to the fixed 4-stage BN/ReLU block, with these additions:
  - independent input/output/coefficient widths;
  - optional round-half-up;
  - saturation with a sticky flag;
  - runtime activation mode (none / ReLU / clipped ReLU);
  - double-buffered runtime-loadable coefficients;
  - valid/ready backpressure.

Parameters:
- NO_CH, 10, number of parallel channels.
- BW_IN, 12, signed input sample width.
- BW_OUT, 12, signed output sample width.
- BW_COEF, 18, signed width of a and b.
- R_SHIFT, 6, arithmetic right shift applied after the bias add; must be ≥1.
- ROUND, 1, 1 = add 2^(R_SHIFT-1) before the shift; 0 = truncate.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- vld_in  in  1  input beat valid.
- rdy_in  out  1  block can accept a beat.
- data_in  in  NO_CH*BW_IN  packed signed samples; channel i at [i].
- vld_out  out  1  output beat valid.
- rdy_out  in  1  downstream accepts.
- data_out  out  NO_CH*BW_OUT  packed signed results.
- act_mode  in  2  0 none, 1 ReLU, 2 clipped ReLU, 3 treated as 1.
- clip_max  in  BW_OUT  unsigned upper bound for mode 2.
- coef_wr  in  1  write strobe to the shadow coefficient bank.
- coef_ch  in  clog2(NO_CH)  channel index for the write.
- coef_a  in  BW_COEF  scale value written to the shadow bank.
- coef_b  in  BW_COEF  bias value written to the shadow bank.
- coef_commit  in  1  copy the shadow bank to the active bank.
- sat_clr  in  1  clear sat_flag.
- sat_flag  out  NO_CH  sticky per-channel saturation indicator.

Behaviour:
- Reset:
  - vld_out=0, data_out=0, sat_flag=0.
  - All pipeline valid bits 0.
  - Both coefficient banks: a=1<<R_SHIFT (unity gain), b=0.
  - rdy_in=1 in the cycle after rst deasserts.
- Pipeline: 4 stages, S1 mult, S2 bias+round, S3 shift+saturate, S4 activation. Stage valids form a shift chain.
- Stall rule: en = ~(vld_out & ~rdy_out). rdy_in = en. All stages, including data and valid registers, advance only when en=1.
- Latency: a beat accepted in cycle t (vld_in & rdy_in) appears on vld_out in cycle t+4 when no stall occurs. Stalls add cycles 1:1.
- Holding outputs: while vld_out=1 and rdy_out=0, data_out and vld_out hold. No beat is lost or duplicated.
- Bubbles: vld_in=0 with en=1 inserts a bubble. Bubbles do not set sat_flag.
- S1: prod = signed(a_act[i]) * signed(x[i]), full width BW_IN+BW_COEF.
- S2: sum = prod + sext(b_act[i]) + (ROUND ? 2^(R_SHIFT-1) : 0). Width is BW_IN+BW_COEF+1, so there is no overflow.
- S3: sh = sum >>> R_SHIFT (arithmetic). If sh > 2^(BW_OUT-1)-1 or sh < -2^(BW_OUT-1), clamp to that bound and set sat_flag[i]. Only valid beats set the flag.
- S4 activation:
  - mode 0: pass-through.
  - mode 1 or 3: output 0 if the value is ≤0.
  - mode 2: ReLU, then min(value, clip_max).
- act_mode/clip_max: sampled at S4 with the beat. Static use is expected; a change mid-stream affects beats in S4 from the next enabled cycle on.
- Coefficients:
  - coef_wr writes shadow[coef_ch] regardless of stall.
  - coef_ch ≥ NO_CH is ignored.
  - coef_commit copies shadow→active in one cycle. S1 uses the active bank, so beats accepted in the cycle after the commit and later use the new values.
  - Beats already past S1 keep their old product.
  - b_act is registered alongside the beat into S2, so a commit never splits one beat between banks.
- coef_wr and coef_commit in the same cycle: the commit copies the pre-write shadow; the write lands in shadow only.
- sat_clr and a new saturation event in the same cycle: the flag ends at 1 (set wins).
- rst mid-stream: all in-flight beats are discarded, and both banks return to unity.

Decomposition:
- Package bn_act_pkg:
  - act_mode_e enum (ACT_NONE, ACT_RELU, ACT_CLIP).
  - Localparams for product/sum widths.
  - Function sat_clamp(value, bw).
- Sub-module bn_act_lane: one channel's S1–S4 datapath.
  - Takes en, stage valids, a_act/b_act and mode.
  - Outputs its data and a sat pulse.
- Top module: generate loop over lanes, valid chain, stall logic, coefficient banks, sat_flag registers.

Test Plan:
- Reset then a single beat with default coefficients, x=100 on all channels, mode 1 → data_out=100 at exactly t+4, vld_out for 1 cycle.
- Load ch0 a=128, b=-64, commit, x=10, R_SHIFT=6, ROUND=1 → (1280-64+32)>>>6 = 19. Same with ROUND=0 → 19 (1216>>>6).
- Overflow: a=(2^17-1), x=2047, mode 0 → data_out=2047, sat_flag[0]=1. Then sat_clr → 0. Negative overflow → -2048.
- Mode 2, clip_max=50, x=100 with unity gain → 50. x=-5 → 0. Mode 0 with x=-5 → -5.
- Backpressure: stream 10 beats with values 1..10, rdy_out toggling 0/1 randomly → output sequence is exactly 1..10 in order, data held during rdy_out=0, rdy_in low whenever the output is stalled.
- Commit mid-stream: beats 1..6, with commit of a=2x unity issued in the cycle beat 3 is accepted → beats 1–3 scale ×1, beats 4–6 scale ×2. Assert rst with 3 beats in flight → no vld_out afterwards, coefficients back to unity.

Source files
------------

// File: rtl/bn_act_pkg.sv
// Shared types, width helpers and the saturating clamp used by the
// batch-norm / activation stage.
package bn_act_pkg;

   typedef enum logic [1:0] {
      ACT_NONE = 2'd0,
      ACT_RELU = 2'd1,
      ACT_CLIP = 2'd2
   } act_mode_e;

   localparam int CLAMP_W     = 64;
   localparam int DEF_BW_IN   = 12;
   localparam int DEF_BW_OUT  = 12;
   localparam int DEF_BW_COEF = 18;
   localparam int DEF_PROD_W  = DEF_BW_IN + DEF_BW_COEF;
   localparam int DEF_SUM_W   = DEF_PROD_W + 1;

   function automatic int prod_width(input int bw_in, input int bw_coef);
      return bw_in + bw_coef;
   endfunction

   // One guard bit over the product keeps prod + bias + round overflow-free.
   function automatic int sum_width(input int bw_in, input int bw_coef);
      return bw_in + bw_coef + 32'sd1;
   endfunction

   function automatic logic signed [CLAMP_W-1:0] sat_clamp(
      input logic signed [CLAMP_W-1:0] value,
      input int                        bw
   );
      logic signed [CLAMP_W-1:0] hi;
      logic signed [CLAMP_W-1:0] lo;
      hi = (64'sd1 <<< (bw - 32'sd1)) - 64'sd1;
      lo = -(64'sd1 <<< (bw - 32'sd1));
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/bn_act_lane.sv
// One channel of the BN/activation datapath: S1 multiply, S2 bias+round,
// S3 shift+saturate, S4 activation. Stage valids are owned by the top.
module bn_act_lane
   import bn_act_pkg::*;
#(
   parameter int BW_IN   = DEF_BW_IN,
   parameter int BW_OUT  = DEF_BW_OUT,
   parameter int BW_COEF = DEF_BW_COEF,
   parameter int R_SHIFT = 6,
   parameter int ROUND   = 1
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       vld_s2,
   input  logic signed [BW_IN-1:0]    x,
   input  logic signed [BW_COEF-1:0]  a_act,
   input  logic signed [BW_COEF-1:0]  b_act,
   input  act_mode_e                  mode,
   input  logic [BW_OUT-1:0]          clip_max,
   output logic signed [BW_OUT-1:0]   y,
   output logic                       sat_pulse
);

   localparam int PROD_W = prod_width(BW_IN, BW_COEF);
   localparam int SUM_W  = sum_width(BW_IN, BW_COEF);
   localparam logic signed [SUM_W-1:0] RND_C = (ROUND != 32'sd0) ?
      SUM_W'(64'sd1 <<< (R_SHIFT - 32'sd1)) : {SUM_W{1'b0}};

   logic signed [PROD_W-1:0]  prod_r;
   logic signed [BW_COEF-1:0] bias_r;
   logic signed [SUM_W-1:0]   sum_r;
   logic signed [BW_OUT-1:0]  sh_r;
   logic signed [BW_OUT-1:0]  y_r;

   logic signed [PROD_W-1:0]  prod_s;
   logic signed [SUM_W-1:0]   sum_s;
   logic signed [SUM_W-1:0]   shift_s;
   logic signed [CLAMP_W-1:0] wide_s;
   logic signed [BW_OUT-1:0]  sat_val_s;
   logic                      sat_s;
   logic signed [BW_OUT-1:0]  act_s;

   // Arithmetic for S1..S3: product, bias + rounding, shift and clamp.
   always_comb begin
      prod_s    = a_act * x;
      sum_s     = $signed({{(SUM_W-PROD_W){prod_r[PROD_W-1]}}, prod_r})
                + $signed({{(SUM_W-BW_COEF){bias_r[BW_COEF-1]}}, bias_r})
                + RND_C;
      shift_s   = sum_r >>> R_SHIFT;
      wide_s    = {{(CLAMP_W-SUM_W){shift_s[SUM_W-1]}}, shift_s};
      sat_val_s = BW_OUT'(sat_clamp(wide_s, BW_OUT));
      sat_s     = (sat_clamp(wide_s, BW_OUT) != wide_s);
      sat_pulse = en & vld_s2 & sat_s;
   end

   // S4 activation; mode 3 shares the ReLU path.
   always_comb begin
      act_s = sh_r;
      case (mode)
         ACT_NONE: begin
            act_s = sh_r;
         end
         ACT_CLIP: begin
            if (sh_r[BW_OUT-1] == 1'b1 || sh_r == {BW_OUT{1'b0}}) begin
               act_s = {BW_OUT{1'b0}};
            end else if ({1'b0, sh_r} > {1'b0, clip_max}) begin
               act_s = clip_max;
            end else begin
               act_s = sh_r;
            end
         end
         default: begin
            if (sh_r[BW_OUT-1] == 1'b1 || sh_r == {BW_OUT{1'b0}}) begin
               act_s = {BW_OUT{1'b0}};
            end else begin
               act_s = sh_r;
            end
         end
      endcase
   end

   // Pipeline data registers; bias travels with the beat into S2.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_r <= {PROD_W{1'b0}};
         bias_r <= {BW_COEF{1'b0}};
         sum_r  <= {SUM_W{1'b0}};
         sh_r   <= {BW_OUT{1'b0}};
         y_r    <= {BW_OUT{1'b0}};
      end else if (en) begin
         prod_r <= prod_s;
         bias_r <= b_act;
         sum_r  <= sum_s;
         sh_r   <= sat_val_s;
         y_r    <= act_s;
      end
   end

   assign y = y_r;

endmodule

// File: rtl/bn_act_sat_fp.sv
// Multi-channel fixed-point batch-norm + activation with saturation flags,
// double-buffered coefficients and valid/ready backpressure.
module bn_act_sat_fp
   import bn_act_pkg::*;
#(
   parameter  int NO_CH   = 10,
   parameter  int BW_IN   = DEF_BW_IN,
   parameter  int BW_OUT  = DEF_BW_OUT,
   parameter  int BW_COEF = DEF_BW_COEF,
   parameter  int R_SHIFT = 6,
   parameter  int ROUND   = 1,
   localparam int CH_W    = (NO_CH > 1) ? $clog2(NO_CH) : 1
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      vld_in,
   output logic                      rdy_in,
   input  logic [NO_CH*BW_IN-1:0]    data_in,
   output logic                      vld_out,
   input  logic                      rdy_out,
   output logic [NO_CH*BW_OUT-1:0]   data_out,
   input  logic [1:0]                act_mode,
   input  logic [BW_OUT-1:0]         clip_max,
   input  logic                      coef_wr,
   input  logic [CH_W-1:0]           coef_ch,
   input  logic [BW_COEF-1:0]        coef_a,
   input  logic [BW_COEF-1:0]        coef_b,
   input  logic                      coef_commit,
   input  logic                      sat_clr,
   output logic [NO_CH-1:0]          sat_flag
);

   localparam logic signed [BW_COEF-1:0] A_UNITY = BW_COEF'(64'sd1 <<< R_SHIFT);

   logic [3:0]                 stg_vld_r;
   logic                       en_s;
   logic                       ch_ok_s;
   act_mode_e                  mode_s;
   logic [NO_CH-1:0]           sat_flag_r;
   logic [NO_CH-1:0]           sat_pulse_s;
   logic signed [BW_COEF-1:0]  shd_a_r [NO_CH];
   logic signed [BW_COEF-1:0]  shd_b_r [NO_CH];
   logic signed [BW_COEF-1:0]  act_a_r [NO_CH];
   logic signed [BW_COEF-1:0]  act_b_r [NO_CH];

   assign en_s    = ~(stg_vld_r[3] & ~rdy_out);
   assign rdy_in  = en_s;
   assign vld_out = stg_vld_r[3];
   assign ch_ok_s = (32'(coef_ch) < NO_CH);
   assign mode_s  = act_mode_e'(act_mode);

   // Stage valid shift chain, frozen while the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld_r <= 4'b0000;
      end else if (en_s) begin
         stg_vld_r <= {stg_vld_r[2:0], vld_in};
      end
   end

   // Coefficient banks: commit copies the pre-write shadow, writes ignore stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NO_CH; i++) begin
            shd_a_r[i] <= A_UNITY;
            shd_b_r[i] <= {BW_COEF{1'b0}};
            act_a_r[i] <= A_UNITY;
            act_b_r[i] <= {BW_COEF{1'b0}};
         end
      end else begin
         if (coef_commit) begin
            for (int i = 0; i < NO_CH; i++) begin
               act_a_r[i] <= shd_a_r[i];
               act_b_r[i] <= shd_b_r[i];
            end
         end
         if (coef_wr && ch_ok_s) begin
            shd_a_r[coef_ch] <= coef_a;
            shd_b_r[coef_ch] <= coef_b;
         end
      end
   end

   // Sticky saturation flags; a same-cycle set overrides the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag_r <= {NO_CH{1'b0}};
      end else begin
         sat_flag_r <= (sat_flag_r & ~{NO_CH{sat_clr}}) | sat_pulse_s;
      end
   end

   assign sat_flag = sat_flag_r;

   for (genvar g = 0; g < NO_CH; g++) begin : g_lane
      bn_act_lane #(
         .BW_IN   (BW_IN),
         .BW_OUT  (BW_OUT),
         .BW_COEF (BW_COEF),
         .R_SHIFT (R_SHIFT),
         .ROUND   (ROUND)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .en        (en_s),
         .vld_s2    (stg_vld_r[1]),
         .x         (data_in[g*BW_IN +: BW_IN]),
         .a_act     (act_a_r[g]),
         .b_act     (act_b_r[g]),
         .mode      (mode_s),
         .clip_max  (clip_max),
         .y         (data_out[g*BW_OUT +: BW_OUT]),
         .sat_pulse (sat_pulse_s[g])
      );
   end

endmodule

// File: tb/tb_bn_act_sat_fp.sv
// Self-checking bench for bn_act_sat_fp: arithmetic reference model with an
// expected-beat queue, plus directed literal checks from worked examples.
module tb_bn_act_sat_fp;

   localparam int NO_CH   = 10;
   localparam int BW_IN   = 12;
   localparam int BW_OUT  = 12;
   localparam int BW_COEF = 18;
   localparam int R_SHIFT = 6;
   localparam int VW      = NO_CH*BW_OUT;

   logic                   clk = 1'b0;
   logic                   rst, vld_in, rdy_out, coef_wr, coef_commit, sat_clr;
   logic [NO_CH*BW_IN-1:0] data_in;
   logic [1:0]             act_mode;
   logic [BW_OUT-1:0]      clip_max;
   logic [3:0]             coef_ch;
   logic [BW_COEF-1:0]     coef_a, coef_b;
   wire                    rdy_in, vld_out, rdy_in_t, vld_out_t;
   wire [VW-1:0]           data_out, data_out_t;
   wire [NO_CH-1:0]        sat_flag, sat_flag_t;

   bn_act_sat_fp #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT), .BW_COEF(BW_COEF),
                   .R_SHIFT(R_SHIFT), .ROUND(1)) dut (
      .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in), .data_in(data_in),
      .vld_out(vld_out), .rdy_out(rdy_out), .data_out(data_out), .act_mode(act_mode),
      .clip_max(clip_max), .coef_wr(coef_wr), .coef_ch(coef_ch), .coef_a(coef_a),
      .coef_b(coef_b), .coef_commit(coef_commit), .sat_clr(sat_clr), .sat_flag(sat_flag));

   bn_act_sat_fp #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT), .BW_COEF(BW_COEF),
                   .R_SHIFT(R_SHIFT), .ROUND(0)) dut_t (
      .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in_t), .data_in(data_in),
      .vld_out(vld_out_t), .rdy_out(rdy_out), .data_out(data_out_t), .act_mode(act_mode),
      .clip_max(clip_max), .coef_wr(coef_wr), .coef_ch(coef_ch), .coef_a(coef_a),
      .coef_b(coef_b), .coef_commit(coef_commit), .sat_clr(sat_clr), .sat_flag(sat_flag_t));

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   longint      ma [NO_CH];
   longint      mb [NO_CH];
   longint      msa[NO_CH];
   longint      msb[NO_CH];
   logic [VW-1:0] exp_q[$];
   int          log0[$];
   int          logt[$];

   task automatic chk(input string nm, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic chkv(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic int lane_of(input logic [VW-1:0] v, input int i);
      logic signed [BW_OUT-1:0] s;
      s = v[i*BW_OUT +: BW_OUT];
      return int'(s);
   endfunction

   // Reference: y = act(clamp((a*x + b + 2^(R-1)) / 2^R floored)).
   function automatic logic [VW-1:0] model(input logic [NO_CH*BW_IN-1:0] din);
      logic [VW-1:0]           r;
      logic signed [BW_IN-1:0] xs;
      longint                  x, v;
      for (int i = 0; i < NO_CH; i++) begin
         xs = din[i*BW_IN +: BW_IN];
         x  = xs;
         v  = (ma[i]*x + mb[i] + (64'sd1 <<< (R_SHIFT-1))) >>> R_SHIFT;
         if (v > 2047)  v = 2047;
         if (v < -2048) v = -2048;
         if (act_mode != 2'd0 && v < 0) v = 0;
         if (act_mode == 2'd2 && v > longint'(clip_max)) v = longint'(clip_max);
         r[i*BW_OUT +: BW_OUT] = v[BW_OUT-1:0];
      end
      return r;
   endfunction

   task automatic bank_reset();
      for (int i = 0; i < NO_CH; i++) begin
         ma[i] = 64; mb[i] = 0; msa[i] = 64; msb[i] = 0;
      end
   endtask

   // Compare process: checks every output cycle, tracks accepted beats and banks.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         bank_reset();
      end else begin
         chk("rdy_in_stall_rule", rdy_in, !(vld_out && !rdy_out));
         if (vld_out) begin
            if (exp_q.size() == 0) begin
               chk("spurious_vld_out", vld_out, 0);
            end else begin
               chkv("data_out", data_out, exp_q[0]);
               if (rdy_out) begin
                  log0.push_back(lane_of(data_out, 0));
                  void'(exp_q.pop_front());
               end
            end
         end
         if (vld_out_t && rdy_out) logt.push_back(lane_of(data_out_t, 0));
         if (vld_in && rdy_in) exp_q.push_back(model(data_in));
         if (coef_commit) begin
            for (int i = 0; i < NO_CH; i++) begin
               ma[i] = msa[i]; mb[i] = msb[i];
            end
         end
         if (coef_wr && coef_ch < NO_CH) begin
            msa[coef_ch] = longint'($signed(coef_a));
            msb[coef_ch] = longint'($signed(coef_b));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_x(input int v);
      for (int i = 0; i < NO_CH; i++) data_in[i*BW_IN +: BW_IN] = BW_IN'(v);
   endtask

   task automatic send(input int v);
      set_x(v); vld_in = 1'b1; tick(); vld_in = 1'b0;
   endtask

   task automatic wr(input int ch, input int a, input int b);
      coef_ch = 4'(ch); coef_a = BW_COEF'(a); coef_b = BW_COEF'(b);
      coef_wr = 1'b1; tick(); coef_wr = 1'b0;
   endtask

   task automatic commit();
      coef_commit = 1'b1; tick(); coef_commit = 1'b0;
   endtask

   task automatic wait_out(input int n);
      for (int c = 0; c < 40; c++) begin
         if (log0.size() >= n) break;
         tick();
      end
      chk("wait_out_count", log0.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k, cyc;
      bit acc;
      bank_reset();
      rst = 1'b1; vld_in = 1'b0; rdy_out = 1'b1; data_in = '0; act_mode = 2'd1;
      clip_max = '0; coef_wr = 1'b0; coef_commit = 1'b0; coef_ch = '0;
      coef_a = '0; coef_b = '0; sat_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_vld_out", vld_out, 0);
      chk("reset_data_out", longint'(data_out == '0), 1);
      chk("reset_sat_flag", sat_flag, 0);
      chk("reset_rdy_in", rdy_in, 1);

      // Single beat, unity gain, exact latency of 4.
      set_x(100); vld_in = 1'b1; tick(); vld_in = 1'b0;
      tick(); tick();
      chk("latency_not_early", vld_out, 0);
      tick();
      chk("latency_t4_vld", vld_out, 1);
      chk("latency_t4_ch0", lane_of(data_out, 0), 100);
      chk("latency_t4_ch9_trunc", lane_of(data_out_t, 9), 100);
      tick();
      chk("single_cycle_vld", vld_out, 0);

      // Loaded coefficients, round-half-up vs truncate.
      wr(0, 128, -64); commit();
      log0.delete(); logt.delete();
      send(10); wait_out(1);
      chk("coef_round_on", log0[0], 19);
      chk("coef_round_off", logt[0], 19);

      // Positive and negative saturation with sticky flag.
      wr(0, 131071, 0); commit(); act_mode = 2'd0;
      log0.delete();
      send(2047); wait_out(1);
      chk("sat_pos_value", log0[0], 2047);
      chk("sat_pos_flag", sat_flag, 1);
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;
      chk("sat_clr", sat_flag, 0);
      send(-2048); wait_out(2);
      chk("sat_neg_value", log0[1], -2048);
      chk("sat_neg_flag", sat_flag, 1);
      sat_clr = 1'b1; tick(); sat_clr = 1'b0;

      // Clipped ReLU and pass-through; out-of-range channel write ignored.
      wr(0, 64, 0); wr(12, 999, 5); commit();
      act_mode = 2'd2; clip_max = 12'd50;
      log0.delete(); logt.delete();
      send(100); wait_out(1);
      chk("clip_high", log0[0], 50);
      send(-5); wait_out(2);
      chk("clip_neg", log0[1], 0);
      act_mode = 2'd0;
      send(-5); wait_out(3);
      chk("mode0_neg", log0[2], -5);
      chk("mode0_neg_trunc", logt[2], -5);

      // Backpressure stream of 1..10 with random rdy_out.
      act_mode = 2'd1; log0.delete();
      k = 1; cyc = 0;
      while (k <= 10 && cyc < 300) begin
         set_x(k); vld_in = 1'b1; rdy_out = 1'($urandom_range(0, 1));
         @(negedge clk); acc = rdy_in;
         @(posedge clk); #1;
         if (acc) k++;
         cyc++;
      end
      vld_in = 1'b0;
      for (int c = 0; c < 300 && log0.size() < 10; c++) begin
         rdy_out = 1'($urandom_range(0, 1)); tick();
      end
      rdy_out = 1'b1;
      chk("bp_count", log0.size(), 10);
      for (int i = 0; i < 10; i++) chk("bp_order", log0[i], i + 1);

      // Commit while streaming; a write in the commit cycle stays in shadow.
      for (int c = 0; c < NO_CH; c++) wr(c, 128, 0);
      log0.delete();
      for (int b = 1; b <= 6; b++) begin
         set_x(b); vld_in = 1'b1;
         if (b == 3) begin
            coef_commit = 1'b1; coef_wr = 1'b1; coef_ch = 4'd1;
            coef_a = BW_COEF'(192); coef_b = '0;
         end
         tick();
         coef_commit = 1'b0; coef_wr = 1'b0;
      end
      vld_in = 1'b0;
      wait_out(6);
      chk("commit_b1", log0[0], 1);
      chk("commit_b3", log0[2], 3);
      chk("commit_b4", log0[3], 8);
      chk("commit_b6", log0[5], 12);
      commit();
      send(10); wait_out(7);
      chk("commit_ch0_x2", log0[6], 20);

      // Reset with beats in flight: nothing emerges, banks return to unity.
      for (int b = 20; b < 23; b++) begin
         set_x(b); vld_in = 1'b1; tick();
      end
      vld_in = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk("rst_flush_vld", vld_out, 0);
         tick();
      end
      chk("rst_flush_count", log0.size(), 7);
      send(100); wait_out(8);
      chk("rst_unity", log0[7], 100);
      repeat (2) tick();
      chk("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
